// File: rtl/impact_sram_sequencer_if.sv
// Request/response port and SRAM head pin bundles for the IMPACT SRAM sequencer.
// master = side that drives the request (req) or the head pins (sram); slave = the other end.
interface impact_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_bank;
  logic [9:0]  req_word;
  logic [31:0] req_wdata;
  logic [3:0]  req_byte_mask;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_bank, req_word, req_wdata, req_byte_mask,
    input  req_ready, rsp_valid, rsp_rdata
  );
  modport slave (
    input  req_valid, req_write, req_bank, req_word, req_wdata, req_byte_mask,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

interface impact_sram_if;
  logic [7:0] sram_data_in;
  logic [7:0] sram_data_out;
  logic [9:0] sram_word_sel;
  logic [1:0] sram_bank_sel;
  logic [1:0] sram_byte_sel;
  logic       sram_write_en;
  logic       sram_read_en;
  logic       sram_precharge;

  modport master (
    output sram_data_in, sram_word_sel, sram_bank_sel, sram_byte_sel,
           sram_write_en, sram_read_en, sram_precharge,
    input  sram_data_out
  );
  modport slave (
    input  sram_data_in, sram_word_sel, sram_bank_sel, sram_byte_sel,
           sram_write_en, sram_read_en, sram_precharge,
    output sram_data_out
  );
endinterface

// File: rtl/impact_sram_sequencer.sv
// Word request -> per-byte precharge/enable(/sample) head sequence; rsp_valid k*(PRE+EN+R)+1 cycles after accept.
// One request in flight: req_ready is high only in IDLE, all outputs registered.
module impact_sram_sequencer #(
  parameter int PRE_CYCLES = 1,
  parameter int EN_CYCLES  = 2
) (
  input logic           clk,
  input logic           rst_n,
  impact_req_if.slave   req,
  impact_sram_if.master sram
);

  localparam logic [3:0] PRE_LOAD = 4'(PRE_CYCLES - 1);
  localparam logic [3:0] EN_LOAD  = 4'(EN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRE    = 3'd1,
    S_ACCESS = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic logic [1:0] lowest_idx(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd3;
    if (m[2]) idx = 2'd2;
    if (m[1]) idx = 2'd1;
    if (m[0]) idx = 2'd0;
    return idx;
  endfunction

  function automatic logic [3:0] clear_bit(input logic [3:0] m, input logic [1:0] idx);
    logic [3:0] r;
    r      = m;
    r[idx] = 1'b0;
    return r;
  endfunction

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [1:0]  r_byte;
  logic [3:0]  r_pend;
  logic        r_write;
  logic [1:0]  r_bank;
  logic [9:0]  r_word;
  logic [31:0] r_wdata;
  logic [31:0] r_acc;

  state_t      w_state_nxt;
  logic [3:0]  w_cnt_nxt;
  logic [1:0]  w_byte_nxt;
  logic [3:0]  w_pend_nxt;
  logic        w_write_nxt;
  logic [1:0]  w_bank_nxt;
  logic [9:0]  w_word_nxt;
  logic [31:0] w_wdata_nxt;
  logic [31:0] w_acc_nxt;
  logic        w_byte_done;

  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic [7:0]  r_data_in;
  logic [9:0]  r_word_sel;
  logic [1:0]  r_bank_sel;
  logic [1:0]  r_byte_sel;
  logic        r_write_en;
  logic        r_read_en;
  logic        r_precharge;

  logic        w_req_ready;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_rdata;
  logic [7:0]  w_data_in;
  logic [9:0]  w_word_sel;
  logic [1:0]  w_bank_sel;
  logic [1:0]  w_byte_sel;
  logic        w_write_en;
  logic        w_read_en;
  logic        w_precharge;

  logic        w_accept;
  logic [1:0]  w_mask_idx;
  logic [1:0]  w_pend_idx;
  logic        w_active_nxt;

  assign w_accept   = req.req_valid & r_req_ready;
  assign w_mask_idx = lowest_idx(req.req_byte_mask);
  assign w_pend_idx = lowest_idx(r_pend);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_byte  <= '0;
      r_pend  <= '0;
      r_write <= 1'b0;
      r_bank  <= '0;
      r_word  <= '0;
      r_wdata <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_byte  <= w_byte_nxt;
      r_pend  <= w_pend_nxt;
      r_write <= w_write_nxt;
      r_bank  <= w_bank_nxt;
      r_word  <= w_word_nxt;
      r_wdata <= w_wdata_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  // r_pend holds the enabled bytes still to do, excluding the one in progress.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_byte_nxt  = r_byte;
    w_pend_nxt  = r_pend;
    w_write_nxt = r_write;
    w_bank_nxt  = r_bank;
    w_word_nxt  = r_word;
    w_wdata_nxt = r_wdata;
    w_acc_nxt   = r_acc;
    w_byte_done = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_write_nxt = req.req_write;
          w_bank_nxt  = req.req_bank;
          w_word_nxt  = req.req_word;
          w_wdata_nxt = req.req_wdata;
          w_acc_nxt   = '0;
          if (req.req_byte_mask == 4'd0) begin
            w_state_nxt = S_DONE;
            w_pend_nxt  = '0;
          end else begin
            w_state_nxt = S_PRE;
            w_cnt_nxt   = PRE_LOAD;
            w_byte_nxt  = w_mask_idx;
            w_pend_nxt  = clear_bit(req.req_byte_mask, w_mask_idx);
          end
        end
      end
      S_PRE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_ACCESS;
          w_cnt_nxt   = EN_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_ACCESS: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else if (r_write) begin
          w_byte_done = 1'b1;
        end else begin
          w_state_nxt = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        // Head output is registered, so the byte is only valid one cycle after read_en drops.
        w_acc_nxt[{r_byte, 3'b000} +: 8] = sram.sram_data_out;
        w_byte_done = 1'b1;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_byte_done) begin
      if (|r_pend) begin
        w_state_nxt = S_PRE;
        w_cnt_nxt   = PRE_LOAD;
        w_byte_nxt  = w_pend_idx;
        w_pend_nxt  = clear_bit(r_pend, w_pend_idx);
      end else begin
        w_state_nxt = S_DONE;
      end
    end
  end

  // Outputs are decoded from next-state values so the registered pins line up with the state.
  always_comb begin
    w_active_nxt = (w_state_nxt == S_PRE) || (w_state_nxt == S_ACCESS) ||
                   (w_state_nxt == S_SAMPLE);
    w_req_ready  = (w_state_nxt == S_IDLE);
    w_rsp_valid  = (w_state_nxt == S_DONE);
    w_rsp_rdata  = r_rsp_rdata;
    if ((w_state_nxt == S_DONE) && !w_write_nxt) begin
      w_rsp_rdata = w_acc_nxt;
    end
    w_precharge = (w_state_nxt == S_PRE);
    w_write_en  = (w_state_nxt == S_ACCESS) && w_write_nxt;
    w_read_en   = (w_state_nxt == S_ACCESS) && !w_write_nxt;
    w_word_sel  = '0;
    w_bank_sel  = '0;
    w_byte_sel  = '0;
    w_data_in   = '0;
    if (w_active_nxt) begin
      w_word_sel = w_word_nxt;
      w_bank_sel = w_bank_nxt;
      w_byte_sel = w_byte_nxt;
      if (w_write_nxt) begin
        w_data_in = w_wdata_nxt[{w_byte_nxt, 3'b000} +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_data_in   <= '0;
      r_word_sel  <= '0;
      r_bank_sel  <= '0;
      r_byte_sel  <= '0;
      r_write_en  <= 1'b0;
      r_read_en   <= 1'b0;
      r_precharge <= 1'b0;
    end else begin
      r_req_ready <= w_req_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_data_in   <= w_data_in;
      r_word_sel  <= w_word_sel;
      r_bank_sel  <= w_bank_sel;
      r_byte_sel  <= w_byte_sel;
      r_write_en  <= w_write_en;
      r_read_en   <= w_read_en;
      r_precharge <= w_precharge;
    end
  end

  assign req.req_ready       = r_req_ready;
  assign req.rsp_valid       = r_rsp_valid;
  assign req.rsp_rdata       = r_rsp_rdata;
  assign sram.sram_data_in   = r_data_in;
  assign sram.sram_word_sel  = r_word_sel;
  assign sram.sram_bank_sel  = r_bank_sel;
  assign sram.sram_byte_sel  = r_byte_sel;
  assign sram.sram_write_en  = r_write_en;
  assign sram.sram_read_en   = r_read_en;
  assign sram.sram_precharge = r_precharge;

endmodule

// File: tb/tb_impact_sram_sequencer.sv
// Randomized bench for impact_sram_sequencer: cycle-accurate pin expectations derived from the
// per-byte timing rules, a byte-array head model, and a shadow memory for read data.
module tb_impact_sram_sequencer;
  localparam int P = 1;
  localparam int E = 2;

  logic clk;
  logic rst_n;
  impact_req_if  rq ();
  impact_sram_if sr ();

  impact_sram_sequencer #(.PRE_CYCLES(P), .EN_CYCLES(E)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rq),
    .sram  (sr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  head_mem [16384];
  logic [7:0]  exp_mem  [16384];
  logic        pl_en;
  logic [13:0] pl_addr;
  logic [7:0]  pl_dat;
  logic [31:0] prev_rdata;

  // Head model: byte array, registered read data.
  always @(posedge clk) begin
    if (pl_en) head_mem[pl_addr] <= pl_dat;
    if (sr.sram_write_en)
      head_mem[{sr.sram_bank_sel, sr.sram_word_sel, sr.sram_byte_sel}] <= sr.sram_data_in;
    if (sr.sram_read_en)
      sr.sram_data_out <= head_mem[{sr.sram_bank_sel, sr.sram_word_sel, sr.sram_byte_sel}];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // {pre, we, re, byte_sel, word_sel, bank_sel, data_in, rsp_valid, req_ready}
  function automatic logic [26:0] got_vec();
    return {sr.sram_precharge, sr.sram_write_en, sr.sram_read_en, sr.sram_byte_sel,
            sr.sram_word_sel, sr.sram_bank_sel, sr.sram_data_in, rq.rsp_valid, rq.req_ready};
  endfunction

  function automatic logic [26:0] exp_vec(input int c, input int n, input logic wr,
                                          input logic [1:0] bank, input logic [9:0] word,
                                          input logic [31:0] wdata, input logic [3:0] mask);
    logic [26:0] v;
    int seglen, seg, off, cnt, idx;
    logic pre, we, re;
    logic [7:0] din;
    v = '0;
    idx = 0;
    cnt = 0;
    if (c < n) begin
      seglen = P + E + (wr ? 0 : 1);
      seg = (c - 1) / seglen;
      off = (c - 1) % seglen;
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          if (cnt == seg) idx = i;
          cnt++;
        end
      end
      pre = (off < P);
      we  = wr && (off >= P) && (off < P + E);
      re  = !wr && (off >= P) && (off < P + E);
      din = wr ? wdata[idx*8 +: 8] : 8'h00;
      v = {pre, we, re, 2'(idx), word, bank, din, 1'b0, 1'b0};
    end else if (c == n) begin
      v = 27'd2;
    end else begin
      v = 27'd1;
    end
    return v;
  endfunction

  task automatic preload(input logic [13:0] addr, input logic [7:0] dat);
    pl_en = 1'b1;
    pl_addr = addr;
    pl_dat = dat;
    exp_mem[addr] = dat;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic rand_fields();
    rq.req_write     = 1'($urandom);
    rq.req_bank      = 2'($urandom);
    rq.req_word      = 10'($urandom);
    rq.req_wdata     = $urandom;
    rq.req_byte_mask = 4'($urandom);
  endtask

  // Starts and ends on a negedge with the DUT idle. rst_at > 0 drops reset during that cycle.
  task automatic txn(input logic wr, input logic [1:0] bank, input logic [9:0] word,
                     input logic [31:0] wdata, input logic [3:0] mask, input logic busy,
                     input int rst_at, output int lat);
    int k, n;
    logic [31:0] new_rd;
    logic [31:0] exp_rd;
    k = $countones(mask);
    n = k * (P + E + (wr ? 0 : 1)) + 1;
    new_rd = '0;
    for (int i = 0; i < 4; i++)
      if (mask[i]) new_rd[i*8 +: 8] = exp_mem[{bank, word, 2'(i)}];
    chk("idle_ready", 64'(rq.req_ready), 64'd1);
    rq.req_valid     = 1'b1;
    rq.req_write     = wr;
    rq.req_bank      = bank;
    rq.req_word      = word;
    rq.req_wdata     = wdata;
    rq.req_byte_mask = mask;
    @(posedge clk);
    lat = 0;
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      if (rq.rsp_valid && lat == 0) lat = c;
      chk($sformatf("pins c%0d", c), 64'(got_vec()), 64'(exp_vec(c, n, wr, bank, word, wdata, mask)));
      exp_rd = (c >= n && !wr) ? new_rd : prev_rdata;
      chk($sformatf("rdata c%0d", c), 64'(rq.rsp_rdata), 64'(exp_rd));
      rand_fields();
      rq.req_valid = (busy && c < n) ? 1'($urandom) : 1'b0;
      if (rst_at == c) begin
        rq.req_valid = 1'b0;
        rst_n = 1'b0;
        break;
      end
    end
    if (rst_at != 0) begin
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        chk("reset_outputs", 64'({got_vec(), rq.rsp_rdata}), 64'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("release_idle", 64'(got_vec()), 64'd1);
      chk("release_rdata", 64'(rq.rsp_rdata), 64'd0);
      prev_rdata = '0;
      lat = -1;
    end else begin
      chk("latency", 64'(lat), 64'(n));
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (mask[i]) exp_mem[{bank, word, 2'(i)}] = wdata[i*8 +: 8];
      end else begin
        prev_rdata = new_rd;
      end
    end
  endtask

  initial begin
    logic [9:0] words [4];
    int lat;
    words = '{10'h000, 10'h155, 10'h2AA, 10'h3FF};
    rst_n = 1'b0;
    pl_en = 1'b0;
    pl_addr = '0;
    pl_dat = '0;
    prev_rdata = '0;
    rq.req_valid = 1'b1;
    rand_fields();
    @(negedge clk);

    for (int b = 0; b < 4; b++)
      for (int w = 0; w < 4; w++)
        for (int y = 0; y < 4; y++)
          preload({2'(b), words[w], 2'(y)}, 8'($urandom));
    preload({2'd1, 10'h2AA, 2'd0}, 8'h11);
    preload({2'd1, 10'h2AA, 2'd1}, 8'h22);
    preload({2'd1, 10'h2AA, 2'd2}, 8'h33);
    preload({2'd1, 10'h2AA, 2'd3}, 8'h44);

    // Reset held with a request pending.
    for (int i = 0; i < 3; i++) begin
      rq.req_valid = 1'b1;
      @(negedge clk);
      chk("reset_hold", 64'({got_vec(), rq.rsp_rdata}), 64'd0);
    end
    rst_n = 1'b1;
    rq.req_valid = 1'b0;
    @(negedge clk);
    chk("reset_release", 64'(got_vec()), 64'd1);

    txn(1'b1, 2'd2, 10'h155, 32'hA5C30F81, 4'hF, 1'b0, 0, lat);
    chk("full_write_lat", 64'(lat), 64'd13);
    txn(1'b0, 2'd1, 10'h2AA, 32'h0, 4'hF, 1'b0, 0, lat);
    chk("full_read_lat", 64'(lat), 64'd17);
    chk("full_read_data", 64'(rq.rsp_rdata), 64'h44332211);
    txn(1'b0, 2'd1, 10'h2AA, 32'h0, 4'b1010, 1'b0, 0, lat);
    chk("partial_read_lat", 64'(lat), 64'd9);
    chk("partial_read_data", 64'(rq.rsp_rdata), 64'h44002200);
    txn(1'b1, 2'd3, 10'h3FF, 32'hDEADBEEF, 4'h0, 1'b0, 0, lat);
    chk("empty_write_lat", 64'(lat), 64'd1);
    txn(1'b0, 2'd3, 10'h3FF, 32'h0, 4'h0, 1'b0, 0, lat);
    chk("empty_read_lat", 64'(lat), 64'd1);
    chk("empty_read_data", 64'(rq.rsp_rdata), 64'd0);
    txn(1'b0, 2'd2, 10'h155, 32'h0, 4'hF, 1'b1, 0, lat);
    chk("readback_busy", 64'(rq.rsp_rdata), 64'hA5C30F81);
    txn(1'b0, 2'd1, 10'h2AA, 32'h0, 4'hF, 1'b0, 10, lat);
    txn(1'b0, 2'd1, 10'h2AA, 32'h0, 4'hF, 1'b0, 0, lat);
    chk("post_reset_lat", 64'(lat), 64'd17);
    chk("post_reset_data", 64'(rq.rsp_rdata), 64'h44332211);

    for (int t = 0; t < 40; t++) begin
      txn(1'($urandom), 2'($urandom), words[$urandom_range(0, 3)], $urandom,
          4'($urandom), 1'($urandom), 0, lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
